// File: rtl/aes_mem_bridge.sv
// Byte-stream front end for the HLS AES_0 core: loads key/plaintext from RX, serves the core's memory ports, streams cipher to TX.
// Optional RUN watchdog enabled by defining AES_BRIDGE_TIMEOUT_EN.
module aes_mem_bridge #(
   parameter  int BLK_BITS       = 128,
   parameter  int KEY_BYTES      = 16,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int PA_W           = $clog2(BLK_BITS),
   localparam int KA_W           = $clog2(KEY_BYTES)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [7:0]      out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            err,
   output logic            ap_start,
   input  logic            ap_done,
   input  logic            ap_idle,
   input  logic            ap_ready,
   input  logic            plain_text_ce0,
   input  logic [PA_W-1:0] plain_text_address0,
   output logic            plain_text_q0,
   input  logic            plain_text_ce1,
   input  logic [PA_W-1:0] plain_text_address1,
   output logic            plain_text_q1,
   input  logic            key_ce0,
   input  logic [KA_W-1:0] key_address0,
   output logic [7:0]      key_q0,
   input  logic            key_ce1,
   input  logic [KA_W-1:0] key_address1,
   output logic [7:0]      key_q1,
   input  logic            cipher_text_ce0,
   input  logic            cipher_text_we0,
   input  logic [PA_W-1:0] cipher_text_address0,
   input  logic            cipher_text_d0,
   input  logic            cipher_text_ce1,
   input  logic            cipher_text_we1,
   input  logic [PA_W-1:0] cipher_text_address1,
   input  logic            cipher_text_d1
);

   typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, RUN, UNLOAD} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic [7:0]            key_mem [KEY_BYTES];
   logic [BLK_BITS-1:0]   pt_mem;
   logic [BLK_BITS-1:0]   cipher_mem;
   logic                  in_fire, out_fire, tmo_hit;
   logic                  unused_inputs;

   assign in_fire       = in_valid & in_ready;
   assign out_fire      = out_valid & out_ready;
   assign out_valid     = (state == UNLOAD);
   assign out_data      = (state == UNLOAD) ? cipher_mem[{cnt, 3'b000} +: 8] : 8'h00;
   assign unused_inputs = ap_idle ^ (TIMEOUT_CYCLES == 0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) state <= LOAD_KEY;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      case (state)
         LOAD_KEY: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 4'd15) state_nxt = LOAD_PT;
         end
         LOAD_PT: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 4'd15) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (ap_done)      state_nxt = UNLOAD;
            else if (tmo_hit) state_nxt = LOAD_KEY;
         end
         UNLOAD: begin
            busy = 1'b1;
            if (out_ready && cnt == 4'd15) state_nxt = LOAD_KEY;
         end
         default: state_nxt = LOAD_KEY;
      endcase
   end

   // cnt wraps naturally to 0 after the 16th byte of each phase; it idles at 0 in RUN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= 4'd0;
         ap_start <= 1'b0;
      end else begin
         if (in_fire || out_fire) cnt <= cnt + 4'd1;
         if (state == LOAD_PT && in_fire && cnt == 4'd15)
            ap_start <= 1'b1;
         else if (state == RUN && (ap_ready || ap_done || tmo_hit))
            ap_start <= 1'b0;
      end
   end

   // NOTE: storage is deliberately left out of reset; its contents are rewritten before any use.
   always_ff @(posedge clk) begin
      if (in_fire && state == LOAD_KEY) key_mem[cnt] <= in_data;
      if (in_fire && state == LOAD_PT)  pt_mem[{cnt, 3'b000} +: 8] <= in_data;
      if (state == RUN) begin
         if (cipher_text_ce0 && cipher_text_we0) cipher_mem[cipher_text_address0] <= cipher_text_d0;
         if (cipher_text_ce1 && cipher_text_we1) cipher_mem[cipher_text_address1] <= cipher_text_d1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         plain_text_q0 <= 1'b0;
         plain_text_q1 <= 1'b0;
         key_q0        <= 8'h00;
         key_q1        <= 8'h00;
      end else begin
         if (plain_text_ce0) plain_text_q0 <= pt_mem[plain_text_address0];
         if (plain_text_ce1) plain_text_q1 <= pt_mem[plain_text_address1];
         if (key_ce0)        key_q0        <= key_mem[key_address0];
         if (key_ce1)        key_q1        <= key_mem[key_address1];
      end
   end

`ifdef AES_BRIDGE_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // tmo_cnt is 0 in the first RUN cycle, so the hit lands on RUN cycle TIMEOUT_CYCLES.
   assign tmo_hit = (state == RUN) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_cnt <= 16'd0;
         err     <= 1'b0;
      end else begin
         tmo_cnt <= (state == RUN) ? tmo_cnt + 16'd1 : 16'd0;
         if (tmo_hit && !ap_done) err <= 1'b1;
         else if (in_fire)        err <= 1'b0;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mem_bridge.sv
// Self-checking bench for aes_mem_bridge: an AES_0 stub reads every key/plaintext address and writes
// cipher = pt ^ {8{key}}; expected output bytes come from the frame the bench itself sent.
module tb_aes_mem_bridge;
`ifdef AES_BRIDGE_TIMEOUT_EN
   // Must exceed the stub's full RUN duration (~131 cycles) so normal frames never time out.
   localparam int TMO = 192;
`else
   localparam int TMO = 4096;
`endif

   logic       clk, reset;
   logic [7:0] in_data, out_data;
   logic       in_valid, in_ready, out_valid, out_ready, busy, err;
   logic       ap_start, ap_done, ap_idle, ap_ready;
   logic       plain_text_ce0, plain_text_ce1, plain_text_q0, plain_text_q1;
   logic [6:0] plain_text_address0, plain_text_address1;
   logic       key_ce0, key_ce1;
   logic [3:0] key_address0, key_address1;
   logic [7:0] key_q0, key_q1;
   logic       cipher_text_ce0, cipher_text_we0, cipher_text_d0;
   logic       cipher_text_ce1, cipher_text_we1, cipher_text_d1;
   logic [6:0] cipher_text_address0, cipher_text_address1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] frm [32];          // [0..15] key bytes, [16..31] plaintext bytes
   logic [7:0] rx_q [$];

   aes_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err(err),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .plain_text_ce0(plain_text_ce0), .plain_text_address0(plain_text_address0), .plain_text_q0(plain_text_q0),
      .plain_text_ce1(plain_text_ce1), .plain_text_address1(plain_text_address1), .plain_text_q1(plain_text_q1),
      .key_ce0(key_ce0), .key_address0(key_address0), .key_q0(key_q0),
      .key_ce1(key_ce1), .key_address1(key_address1), .key_q1(key_q1),
      .cipher_text_ce0(cipher_text_ce0), .cipher_text_we0(cipher_text_we0),
      .cipher_text_address0(cipher_text_address0), .cipher_text_d0(cipher_text_d0),
      .cipher_text_ce1(cipher_text_ce1), .cipher_text_we1(cipher_text_we1),
      .cipher_text_address1(cipher_text_address1), .cipher_text_d1(cipher_text_d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic rand_frame();
      for (int i = 0; i < 32; i++) frm[i] = 8'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_wait: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         send_byte(frm[i]);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   // Behavioural AES_0 stand-in: pulses ap_ready, reads everything, writes pt ^ key, raises ap_done.
   task automatic run_stub(input bit conflict);
      logic [7:0]   k [16];
      logic [127:0] p;
      int           n = 0;
      while (ap_start !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (ap_start !== 1'b1) begin
         n_fail++;
         $display("FAIL stub_start: ap_start=%b required 1", ap_start);
         return;
      end
      ap_ready = 1'b1;
      for (int j = 0; j <= 64; j++) begin
         if (j > 0) begin
            p[2*j-2] = plain_text_q0;
            p[2*j-1] = plain_text_q1;
            if (j <= 8) begin
               k[2*j-2] = key_q0;
               k[2*j-1] = key_q1;
            end
         end
         plain_text_ce0      = (j < 64);
         plain_text_ce1      = (j < 64);
         plain_text_address0 = 7'(2*j);
         plain_text_address1 = 7'(2*j + 1);
         key_ce0             = (j < 8);
         key_ce1             = (j < 8);
         key_address0        = 4'(2*j);
         key_address1        = 4'(2*j + 1);
         @(negedge clk);
         ap_ready = 1'b0;
         if (j == 0) begin
            n_tests++;
            if (ap_start !== 1'b0) begin
               n_fail++;
               $display("FAIL ap_start_clear: ap_start=%b required 0", ap_start);
            end
         end
      end
      for (int j = 0; j < 64; j++) begin
         cipher_text_ce0 = 1'b1; cipher_text_we0 = 1'b1;
         cipher_text_ce1 = 1'b1; cipher_text_we1 = 1'b1;
         cipher_text_address0 = 7'(2*j);
         cipher_text_address1 = 7'(2*j + 1);
         cipher_text_d0 = p[2*j]     ^ k[j/4][(2*j) % 8];
         cipher_text_d1 = p[2*j + 1] ^ k[j/4][(2*j + 1) % 8];
         @(negedge clk);
      end
      ap_done = 1'b1;
      cipher_text_ce0 = conflict; cipher_text_we0 = conflict;
      cipher_text_ce1 = conflict; cipher_text_we1 = conflict;
      cipher_text_address0 = 7'd5; cipher_text_d0 = 1'b0;
      cipher_text_address1 = 7'd5; cipher_text_d1 = 1'b1;
      @(negedge clk);
      // Stray write in UNLOAD must be ignored.
      ap_done = 1'b0;
      cipher_text_ce0 = 1'b1; cipher_text_we0 = 1'b1;
      cipher_text_ce1 = 1'b0; cipher_text_we1 = 1'b0;
      cipher_text_address0 = 7'd0;
      cipher_text_d0 = ~(p[0] ^ k[0][0]);
      @(negedge clk);
      cipher_text_ce0 = 1'b0; cipher_text_we0 = 1'b0;
   endtask

   // Collects 16 beats; out_ready is held low for the first 'stall' valid cycles, then random.
   task automatic recv_frame(input int stall);
      int         n = 0, beats = 0, seen = 0;
      logic       pend = 1'b0;
      logic [7:0] held = 8'h00;
      rx_q.delete();
      while (beats < 16 && n < 2000) begin
         if (pend) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_fail++;
               $display("FAIL stall_hold: out_valid=%b out_data=%h required 1/%h", out_valid, out_data, held);
            end
         end
         if (out_valid === 1'b1) begin
            out_ready = (seen >= stall) && ($urandom_range(0, 3) != 0);
            seen++;
            pend = !out_ready;
            held = out_data;
            if (out_ready) begin
               rx_q.push_back(out_data);
               beats++;
            end
         end else begin
            out_ready = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      out_ready = 1'b0;
      n_tests++;
      if (beats != 16) begin
         n_fail++;
         $display("FAIL rx_count: beats=%0d required 16", beats);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || ap_start !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: in_ready=%b busy=%b ap_start=%b err=%b required 1/0/0/0",
                  in_ready, busy, ap_start, err);
      end
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_out: out_valid=%b out_data=%h required 0/00", out_valid, out_data);
      end
      n_tests++;
      if (plain_text_q0 !== 1'b0 || plain_text_q1 !== 1'b0 || key_q0 !== 8'h00 || key_q1 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_q: pt_q=%b%b key_q0=%h key_q1=%h required 00/00/00",
                  plain_text_q1, plain_text_q0, key_q0, key_q1);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_known_vector();
      logic [7:0] got;
      for (int i = 0; i < 16; i++) begin
         frm[i]      = 8'(i);
         frm[16 + i] = 8'(i * 8'h11);
      end
      send_range(0, 30, 1'b0);
      n_tests++;
      if (ap_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_start: ap_start=%b in_ready=%b busy=%b required 0/1/0", ap_start, in_ready, busy);
      end
      send_range(31, 31, 1'b0);
      n_tests++;
      if (ap_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_rise: ap_start=%b in_ready=%b busy=%b required 1/0/1", ap_start, in_ready, busy);
      end
      fork
         run_stub(1'b0);
         recv_frame(0);
      join
      for (int i = 0; i < 16; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_tests++;
         if (got !== 8'(i * 16)) begin
            n_fail++;
            $display("FAIL known_byte%0d: got %h required %h", i, got, 8'(i * 16));
         end
      end
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL unload_end: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_read_ports();
      logic [7:0] got;
      int         r;
      rand_frame();
      for (int i = 0; i < 16; i++) frm[i] = 8'(i);
      frm[16] = 8'h01;
      r = $urandom_range(0, 15);
      send_range(0, 16, 1'b0);
      plain_text_ce0 = 1'b1; plain_text_address0 = 7'd0;
      plain_text_ce1 = 1'b1; plain_text_address1 = 7'd1;
      key_ce0 = 1'b1; key_address0 = 4'd3;
      key_ce1 = 1'b1; key_address1 = 4'(r);
      @(negedge clk);
      n_tests++;
      if (plain_text_q0 !== 1'b1 || plain_text_q1 !== 1'b0) begin
         n_fail++;
         $display("FAIL pt_read: q0=%b q1=%b required 1/0", plain_text_q0, plain_text_q1);
      end
      n_tests++;
      if (key_q0 !== 8'h03 || key_q1 !== frm[r]) begin
         n_fail++;
         $display("FAIL key_read: q0=%h q1=%h required 03/%h", key_q0, key_q1, frm[r]);
      end
      plain_text_ce0 = 1'b0; plain_text_address0 = 7'd1;
      plain_text_ce1 = 1'b0;
      key_ce0 = 1'b0; key_address0 = 4'd7;
      key_ce1 = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (plain_text_q0 !== 1'b1 || key_q0 !== 8'h03) begin
         n_fail++;
         $display("FAIL read_hold: pt_q0=%b key_q0=%h required 1/03", plain_text_q0, key_q0);
      end
      send_range(17, 31, 1'b0);
      fork
         run_stub(1'b0);
         recv_frame(3);
      join
      for (int i = 0; i < 16; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_tests++;
         if (got !== (frm[16 + i] ^ frm[i])) begin
            n_fail++;
            $display("FAIL read_frame_byte%0d: got %h required %h", i, got, frm[16 + i] ^ frm[i]);
         end
      end
   endtask

   task automatic test_write_conflict();
      logic [7:0] got, exp;
      rand_frame();
      frm[16][5] = frm[0][5];
      send_range(0, 31, 1'b0);
      fork
         run_stub(1'b1);
         recv_frame(3);
      join
      for (int i = 0; i < 16; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         exp = frm[16 + i] ^ frm[i];
         if (i == 0) exp = exp | 8'h20;
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL conflict_byte%0d: got %h required %h", i, got, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] got;
      rand_frame();
      send_range(0, 31, 1'b0);
      fork
         run_stub(1'b0);
         recv_frame(10);
      join
      for (int i = 0; i < 16; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_tests++;
         if (got !== (frm[16 + i] ^ frm[i])) begin
            n_fail++;
            $display("FAIL bp_byte%0d: got %h required %h", i, got, frm[16 + i] ^ frm[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      for (int f = 0; f < 3; f++) begin
         rand_frame();
         send_range(0, 31, f[0]);
         fork
            run_stub(1'b0);
            recv_frame(f);
         join
         for (int i = 0; i < 16; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== (frm[16 + i] ^ frm[i])) begin
               n_fail++;
               $display("FAIL b2b_f%0d_byte%0d: got %h required %h", f, i, got, frm[16 + i] ^ frm[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] got;
      rand_frame();
      send_range(0, 31, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) @(negedge clk);
      n_tests++;
      if (ap_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL run_stall: ap_start=%b busy=%b in_ready=%b out_valid=%b required 1/1/0/0",
                  ap_start, busy, in_ready, out_valid);
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      reset    = 1'b1;
      n_tests++;
      if (ap_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: ap_start=%b in_ready=%b busy=%b err=%b required 0/1/0/0",
                  ap_start, in_ready, busy, err);
      end
      rand_frame();
      send_range(0, 31, 1'b0);
      fork
         run_stub(1'b0);
         recv_frame(2);
      join
      for (int i = 0; i < 16; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_tests++;
         if (got !== (frm[16 + i] ^ frm[i])) begin
            n_fail++;
            $display("FAIL fresh_byte%0d: got %h required %h", i, got, frm[16 + i] ^ frm[i]);
         end
      end
   endtask

   task automatic test_timeout();
`ifdef AES_BRIDGE_TIMEOUT_EN
      logic early = 1'b0;
      rand_frame();
      send_range(0, 31, 1'b0);
      for (int c = 1; c <= TMO; c++) begin
         if (err !== 1'b0 || out_valid !== 1'b0 || ap_start !== 1'b1) early = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (early) begin
         n_fail++;
         $display("FAIL tmo_early: premature err/out_valid/ap_start change, flag=%b required 0", early);
      end
      n_tests++;
      if (err !== 1'b1 || ap_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_fire: err=%b ap_start=%b in_ready=%b busy=%b out_valid=%b required 1/0/1/0/0",
                  err, ap_start, in_ready, busy, out_valid);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_sticky: err=%b out_valid=%b required 1/0", err, out_valid);
      end
      send_byte(8'($urandom));
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_clear: err=%b required 0", err);
      end
`endif
   endtask

   initial begin
      reset = 1'b0;
      in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
      plain_text_ce0 = 1'b0; plain_text_ce1 = 1'b0;
      plain_text_address0 = 7'd0; plain_text_address1 = 7'd0;
      key_ce0 = 1'b0; key_ce1 = 1'b0; key_address0 = 4'd0; key_address1 = 4'd0;
      cipher_text_ce0 = 1'b0; cipher_text_we0 = 1'b0; cipher_text_d0 = 1'b0;
      cipher_text_ce1 = 1'b0; cipher_text_we1 = 1'b0; cipher_text_d1 = 1'b0;
      cipher_text_address0 = 7'd0; cipher_text_address1 = 7'd0;
      @(negedge clk);
      test_reset();
      test_known_vector();
      test_read_ports();
      test_write_conflict();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
